// File: rtl/branch_predictor_bht_if.sv
// Predictor bundle: IF lookup, EX resolve/redirect and flushes.
// Stats ports exist only when BP_STATS_EN is defined.
interface branch_predictor_bht_if #(
  parameter int XLEN = 32
);
  logic            if_pc_dummy_unused;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic [XLEN-1:0] if_pred_target;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            IF_flush;
  logic            ID_flush;
  logic            EX_flush;
`ifdef BP_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  assign if_pc_dummy_unused = 1'b0;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc,
    output ex_taken, ex_target,
    output ex_pred_taken, ex_pred_target,
    input  if_pred_taken, if_pred_target,
    input  mispredict, redirect_pc,
    input  IF_flush, ID_flush, EX_flush
`ifdef BP_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc,
    input  ex_taken, ex_target,
    input  ex_pred_taken, ex_pred_target,
    output if_pred_taken, if_pred_target,
    output mispredict, redirect_pc,
    output IF_flush, ID_flush, EX_flush
`ifdef BP_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_predictor_bht.sv
// Tagged 2-bit BHT + BTB: IF lookup, EX resolve/train/redirect.
// Ports: clk, rst_n (async low), bp (slave); BP_STATS_EN adds stats.
module branch_predictor_bht #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter int         TAG_WIDTH = 8,
  parameter logic [1:0] CTR_INIT  = 2'd1
) (
  input logic clk,
  input logic rst_n,
  branch_predictor_bht_if.slave bp
);
  localparam int IDX_W  = $clog2(BHT_DEPTH);
  localparam int TAG_HI = IDX_W + 2 + TAG_WIDTH;

  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;

  logic            valid_q  [BHT_DEPTH];
  tag_t            tag_q    [BHT_DEPTH];
  logic [1:0]      ctr_q    [BHT_DEPTH];
  logic [XLEN-1:0] target_q [BHT_DEPTH];

  idx_t            if_idx;
  tag_t            if_tag;
  logic            if_hit;
  logic [XLEN-1:0] if_pc4;

  idx_t            ex_idx;
  tag_t            ex_tag;
  logic            ex_hit;
  logic [XLEN-1:0] ex_pc4;
  logic            res;
  logic            mis;
  logic [1:0]      ctr_cur;
  logic [1:0]      ctr_nxt;

  assign if_idx = bp.if_pc[IDX_W+1:2];
  assign if_tag = bp.if_pc[IDX_W+2 +: TAG_WIDTH];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pc4 = bp.if_pc + XLEN'(4);

  assign bp.if_pred_taken  = if_hit && ctr_q[if_idx][1];
  assign bp.if_pred_target = bp.if_pred_taken ? target_q[if_idx] : if_pc4;

  assign ex_idx = bp.ex_pc[IDX_W+1:2];
  assign ex_tag = bp.ex_pc[IDX_W+2 +: TAG_WIDTH];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_pc4 = bp.ex_pc + XLEN'(4);

  assign res = bp.ex_valid && bp.ex_is_branch;

  // Held low during reset so no redirect escapes while the table clears.
  assign mis = rst_n && res &&
    ((bp.ex_taken != bp.ex_pred_taken) ||
     (bp.ex_taken && bp.ex_pred_taken &&
      (bp.ex_target != bp.ex_pred_target)));

  assign bp.mispredict  = mis;
  assign bp.IF_flush    = mis;
  assign bp.ID_flush    = mis;
  assign bp.EX_flush    = mis;
  assign bp.redirect_pc = (mis && bp.ex_taken) ? bp.ex_target : ex_pc4;

  assign ctr_cur = ctr_q[ex_idx];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (bp.ex_taken) begin
      if (ctr_cur != 2'd3) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'd0) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_INIT;
        target_q[i] <= '0;
      end
    end else if (res) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_nxt;
        if (bp.ex_taken) target_q[ex_idx] <= bp.ex_target;
      end else if (bp.ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        ctr_q[ex_idx]    <= 2'd2;
        target_q[ex_idx] <= bp.ex_target;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (res && stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
      if (mis && stat_mis_q != '1) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mis_q;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.if_pc[1:0], bp.if_pc[XLEN-1:TAG_HI],
                            bp.ex_pc[1:0], bp.ex_pc[XLEN-1:TAG_HI]};
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht.
// Drives at negedge, checks #1 later, updates land on posedge.
module tb_branch_predictor_bht;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  branch_predictor_bht_if #(.XLEN(32)) bp ();

  branch_predictor_bht dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic ex_set(input logic v, input logic br,
                        input logic [31:0] pc, input logic tk,
                        input logic [31:0] tg, input logic ptk,
                        input logic [31:0] ptg);
    bp.ex_valid       = v;
    bp.ex_is_branch   = br;
    bp.ex_pc          = pc;
    bp.ex_taken       = tk;
    bp.ex_target      = tg;
    bp.ex_pred_taken  = ptk;
    bp.ex_pred_target = ptg;
  endtask

  task automatic idle();
    @(negedge clk);
    ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tg);
    idle();
    bp.if_pc = pc;
    #1;
    chk({tag, "_tk"}, {31'b0, bp.if_pred_taken}, {31'b0, tk});
    chk({tag, "_tg"}, bp.if_pred_target, tg);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tg,
                         input logic ptk, input logic [31:0] ptg,
                         input logic mis, input logic [31:0] rpc);
    @(negedge clk);
    ex_set(1'b1, 1'b1, pc, tk, tg, ptk, ptg);
    #1;
    chk({tag, "_mis"}, {31'b0, bp.mispredict}, {31'b0, mis});
    if (mis) begin
      chk({tag, "_rpc"}, bp.redirect_pc, rpc);
      chk({tag, "_fl"},
          {29'b0, bp.IF_flush, bp.ID_flush, bp.EX_flush}, 32'h7);
    end
  endtask

  initial begin
    bp.if_pc = 32'h100;
    ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    #1;
    chk("rst_tk", {31'b0, bp.if_pred_taken}, 32'h0);
    chk("rst_tg", bp.if_pred_target, 32'h104);
    chk("rst_fl", {28'b0, bp.mispredict, bp.IF_flush,
                   bp.ID_flush, bp.EX_flush}, 32'h0);

    resolve("alloc", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,
            1'b1, 32'h80);
    look("alloc_lk", 32'h100, 1'b1, 32'h80);

    resolve("nt1", 32'h100, 1'b0, 32'h0, 1'b1, 32'h80,
            1'b1, 32'h104);
    look("nt1_lk", 32'h100, 1'b0, 32'h104);
    resolve("nt2", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0,
            1'b0, 32'h0);
    look("nt2_lk", 32'h100, 1'b0, 32'h104);

    resolve("up1", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,
            1'b1, 32'h80);
    look("up1_lk", 32'h100, 1'b0, 32'h104);
    resolve("up2", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,
            1'b1, 32'h80);
    look("up2_lk", 32'h100, 1'b1, 32'h80);

    for (int i = 0; i < 4; i++)
      resolve("sat", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80,
              1'b0, 32'h0);
    resolve("tgt", 32'h100, 1'b1, 32'h88, 1'b1, 32'h80,
            1'b1, 32'h88);
    look("tgt_lk", 32'h100, 1'b1, 32'h88);
    resolve("dn1", 32'h100, 1'b0, 32'h0, 1'b1, 32'h88,
            1'b1, 32'h104);
    look("dn1_lk", 32'h100, 1'b1, 32'h88);
    resolve("dn2", 32'h100, 1'b0, 32'h0, 1'b1, 32'h88,
            1'b1, 32'h104);
    look("dn2_lk", 32'h100, 1'b0, 32'h104);

    @(negedge clk);
    ex_set(1'b0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    chk("bub_mis", {31'b0, bp.mispredict}, 32'h0);
    @(negedge clk);
    ex_set(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    chk("nbr_mis", {31'b0, bp.mispredict}, 32'h0);
    look("bub_lk", 32'h100, 1'b0, 32'h104);

    resolve("alias", 32'h200, 1'b1, 32'h40, 1'b0, 32'h0,
            1'b1, 32'h40);
    look("alias_old", 32'h100, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 32'h40);

    look("wrap_lk", 32'hFFFF_FFFC, 1'b0, 32'h0);
    resolve("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10,
            1'b1, 32'h0);

    @(negedge clk);
    bp.if_pc = 32'h200;
    ex_set(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("mrst_tk", {31'b0, bp.if_pred_taken}, 32'h0);
    chk("mrst_tg", bp.if_pred_target, 32'h204);
    chk("mrst_fl", {28'b0, bp.mispredict, bp.IF_flush,
                    bp.ID_flush, bp.EX_flush}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    look("mrst_lk", 32'h200, 1'b0, 32'h204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
